tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
Multi-channel clock-enable scheduler built on a shared base prescaler. One base divider derives a BaseTick strobe from Clk. Each channel counts BaseTicks and emits single-cycle enable pulses, periodic or one-shot, at a runtime-programmed period. It replaces per-consumer dividers: UART baud, debounce, display refresh and timeouts all share one prescaler and request ticks through a config handshake.

Parameters:
FREQUENCY_IN, 50_000_000, Clk frequency in Hz.
BASE_FREQUENCY, 1_000_000, BaseTick rate in Hz. BASE_DIV = FREQUENCY_IN / BASE_FREQUENCY (integer division). BASE_DIV < 1 is an elaboration error.
CHANNELS, 4, number of tick channels, 1..16.
PERIOD_WIDTH, 16, width of the per-channel period, in BaseTicks.

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous, active-low reset.
CfgValid  in  1  config request.
CfgReady  out  1  config accept; a write occurs when CfgValid and CfgReady are both high.
CfgChannel  in  max(1,$clog2(CHANNELS))  target channel. Indices >= CHANNELS are accepted and ignored.
CfgPeriod  in  PERIOD_WIDTH  period P in BaseTicks.
CfgMode  in  2  00 stop, 01 periodic, 10 one-shot, 11 reserved (treated as stop).
BaseTick  out  1  one-cycle strobe every BASE_DIV cycles.
ChannelTick  out  CHANNELS  per-channel one-cycle enable pulse.
ChannelActive  out  CHANNELS  channel running (PERIODIC or ONESHOT).

Behaviour:
- Reset (Reset low at a Clk edge): all counters 0; all channels IDLE; BaseTick, ChannelTick, ChannelActive and CfgReady all 0. Reset mid-operation aborts everything with no trailing pulses.
- Base prescaler: counter runs 0..BASE_DIV-1; BaseTick is registered and high for the one cycle after the counter wraps. First BaseTick occurs BASE_DIV cycles after reset release. If BASE_DIV == 1, BaseTick is constantly high.
- CfgReady: 1 in the first cycle after reset release. After each accepted write it drops to 0 for exactly one cycle, then returns to 1. Sustained write throughput is therefore 1 per 2 cycles.
- Per-channel state machine, states IDLE / PERIODIC / ONESHOT:
  - Accepted write, mode 01, P >= 1: load counter with P-1, go to PERIODIC.
  - Accepted write, mode 10, P >= 1: load counter with P-1, go to ONESHOT.
  - Accepted write, mode 00 or 11, or P == 0: go to IDLE. Any pending tick is discarded.
  - In PERIODIC or ONESHOT, on each BaseTick cycle: if counter == 0, ChannelTick[i] goes high in the next cycle; PERIODIC reloads P-1, ONESHOT goes to IDLE. Otherwise the counter decrements.
  - The first pulse therefore follows the P-th BaseTick after the write. Period between pulses is P*BASE_DIV Clk cycles.
- ChannelTick latency: exactly 1 cycle after the triggering BaseTick. Pulse width is always 1 cycle. All channels sharing the same expiry pulse in the same cycle.
- ChannelActive[i]: registered; equals (state != IDLE). In ONESHOT it drops in the same cycle the final ChannelTick[i] rises.
- Write to a channel in the same cycle as its BaseTick: the write wins. The expiry, decrement and pulse for that BaseTick are dropped, and the new period counts from the following BaseTick.
- A write to channel i never perturbs any other channel or the base prescaler.
- Period arithmetic is unsigned PERIOD_WIDTH with no wrap. The counter never decrements below 0. Maximum P = 2^PERIOD_WIDTH - 1.

Optional Feature:
TICK_SCHEDULER_DONE_FLAGS_EN
- Defined: adds output DoneFlags (width CHANNELS). DoneFlags[i] is set, sticky, in the same cycle a ONESHOT channel's final ChannelTick[i] asserts. It is cleared by any accepted write to channel i and by reset. A write and a set in the same cycle resolve to cleared.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use FREQUENCY_IN=8, BASE_FREQUENCY=2 (BASE_DIV=4), CHANNELS=4, PERIOD_WIDTH=8.
1. Reset low 5 cycles, then high -> all outputs 0 during reset; CfgReady=1 at the first cycle after release; BaseTick high at cycles 4, 8, 12, ... after release.
2. Write ch0, mode 01, P=3 -> ChannelTick[0] rises 1 cycle after the 3rd subsequent BaseTick, then every 12 cycles; ChannelActive[0]=1 throughout.
3. Write ch1, mode 10, P=2 -> exactly one ChannelTick[1] pulse; ChannelActive[1] 1 then 0 with that pulse; DoneFlags[1]=1 with the macro defined.
4. Hold CfgValid for ch2 P=1 then ch3 P=1 on consecutive cycles -> second write accepted 2 cycles after the first (CfgReady low 1 cycle); both channels then pulse every 4 cycles, in the same cycle.
5. Write ch0 mode 00 in the BaseTick cycle that would expire it -> no ChannelTick[0]; ChannelActive[0]=0 next cycle. Write with P=0 mode 01 -> channel stays IDLE.
6. Reset asserted while ch0 is periodic with counter == 0 -> no pulse; all state IDLE; after release, no ticks until reprogrammed.

Source files
------------

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: one shared base prescaler, CHANNELS programmable tick channels.
// Optional sticky one-shot completion flags (DoneFlags_o) are built when TICK_SCHEDULER_DONE_FLAGS_EN is defined.

module tick_scheduler #(
   parameter  int unsigned FREQUENCY_IN   = 50_000_000,
   parameter  int unsigned BASE_FREQUENCY = 1_000_000,
   parameter  int unsigned CHANNELS       = 4,
   parameter  int unsigned PERIOD_WIDTH   = 16,
   localparam int unsigned CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    CfgValid_i,
   output logic                    CfgReady_o,
   input  logic [CH_W-1:0]         CfgChannel_i,
   input  logic [PERIOD_WIDTH-1:0] CfgPeriod_i,
   input  logic [1:0]              CfgMode_i,
   output logic                    BaseTick_o,
   output logic [CHANNELS-1:0]     ChannelTick_o,
   output logic [CHANNELS-1:0]     ChannelActive_o
`ifdef TICK_SCHEDULER_DONE_FLAGS_EN
   ,
   output logic [CHANNELS-1:0]     DoneFlags_o
`endif
);

   localparam int unsigned BASE_DIV  = FREQUENCY_IN / BASE_FREQUENCY;
   localparam int unsigned BASE_W    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PERIODIC = 2'd1;
   localparam logic [1:0] ST_ONESHOT  = 2'd2;

   localparam logic [1:0] MODE_PERIODIC = 2'b01;
   localparam logic [1:0] MODE_ONESHOT  = 2'b10;

   localparam logic [PERIOD_WIDTH-1:0] P_ZERO = {PERIOD_WIDTH{1'b0}};
   localparam logic [PERIOD_WIDTH-1:0] P_ONE  = PERIOD_WIDTH'(1);

   generate
      if (BASE_DIV < 1) begin : g_bad_base_div
         $error("tick_scheduler: FREQUENCY_IN / BASE_FREQUENCY must be at least 1");
      end
      if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
         $error("tick_scheduler: CHANNELS must be in 1..16");
      end
   endgenerate

   logic [BASE_W-1:0]                      base_cnt_q, base_cnt_d;
   logic                                   base_tick_q, base_tick_d;
   logic                                   cfg_ready_q, cfg_ready_d;
   logic                                   cfg_accept_s;
   logic [CHANNELS-1:0][1:0]               state_q, state_d;
   logic [CHANNELS-1:0][PERIOD_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CHANNELS-1:0][PERIOD_WIDTH-1:0]  period_q, period_d;
   logic [CHANNELS-1:0]                    tick_q, tick_d;
   logic [CHANNELS-1:0]                    active_q, active_d;
   logic [CHANNELS-1:0]                    wr_hit_s;
   logic [CHANNELS-1:0]                    expire_s;

   // Base prescaler next state: BaseTick is raised for the cycle after the counter wraps.
   always_comb begin
      base_cnt_d  = base_cnt_q;
      base_tick_d = 1'b0;
      if (base_cnt_q == BASE_LAST) begin
         base_cnt_d  = {BASE_W{1'b0}};
         base_tick_d = 1'b1;
      end else begin
         base_cnt_d  = base_cnt_q + BASE_W'(1);
         base_tick_d = 1'b0;
      end
   end

   // Config handshake: ready drops for exactly one cycle after every accepted write.
   always_comb begin
      cfg_accept_s = CfgValid_i & cfg_ready_q;
      cfg_ready_d  = ~cfg_accept_s;
   end

   // Channel next state; a write to a channel overrides that channel's BaseTick work in the same cycle.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit_s[i] = cfg_accept_s & (CfgChannel_i == CH_W'(i));
         expire_s[i] = base_tick_q & (state_q[i] != ST_IDLE) &
                       (cnt_q[i] == P_ZERO) & ~wr_hit_s[i];
         state_d[i]  = state_q[i];
         cnt_d[i]    = cnt_q[i];
         period_d[i] = period_q[i];
         if (wr_hit_s[i]) begin
            period_d[i] = CfgPeriod_i;
            case (CfgMode_i)
               MODE_PERIODIC: begin
                  if (CfgPeriod_i != P_ZERO) begin
                     state_d[i] = ST_PERIODIC;
                     cnt_d[i]   = CfgPeriod_i - P_ONE;
                  end else begin
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = P_ZERO;
                  end
               end
               MODE_ONESHOT: begin
                  if (CfgPeriod_i != P_ZERO) begin
                     state_d[i] = ST_ONESHOT;
                     cnt_d[i]   = CfgPeriod_i - P_ONE;
                  end else begin
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = P_ZERO;
                  end
               end
               default: begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = P_ZERO;
               end
            endcase
         end else if (expire_s[i]) begin
            if (state_q[i] == ST_PERIODIC) begin
               state_d[i] = ST_PERIODIC;
               cnt_d[i]   = period_q[i] - P_ONE;
            end else begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = P_ZERO;
            end
         end else if (base_tick_q && (state_q[i] != ST_IDLE)) begin
            cnt_d[i] = cnt_q[i] - P_ONE;
         end else begin
            cnt_d[i] = cnt_q[i];
         end
         tick_d[i]   = expire_s[i];
         active_d[i] = (state_d[i] != ST_IDLE);
      end
   end

   // State registers; synchronous active-low reset clears everything, including in-flight pulses.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         base_cnt_q  <= {BASE_W{1'b0}};
         base_tick_q <= 1'b0;
         cfg_ready_q <= 1'b0;
         state_q     <= {CHANNELS{ST_IDLE}};
         cnt_q       <= {CHANNELS{P_ZERO}};
         period_q    <= {CHANNELS{P_ZERO}};
         tick_q      <= {CHANNELS{1'b0}};
         active_q    <= {CHANNELS{1'b0}};
      end else begin
         base_cnt_q  <= base_cnt_d;
         base_tick_q <= base_tick_d;
         cfg_ready_q <= cfg_ready_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         tick_q      <= tick_d;
         active_q    <= active_d;
      end
   end

   assign BaseTick_o      = base_tick_q;
   assign CfgReady_o      = cfg_ready_q;
   assign ChannelTick_o   = tick_q;
   assign ChannelActive_o = active_q;

`ifdef TICK_SCHEDULER_DONE_FLAGS_EN
   logic [CHANNELS-1:0] done_q, done_d;

   // Sticky completion flags: set by a one-shot's final pulse, cleared by any write to that channel.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (wr_hit_s[i]) begin
            done_d[i] = 1'b0;
         end else if (expire_s[i] && (state_q[i] != ST_PERIODIC)) begin
            done_d[i] = 1'b1;
         end else begin
            done_d[i] = done_q[i];
         end
      end
   end

   // Done flag register.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         done_q <= {CHANNELS{1'b0}};
      end else begin
         done_q <= done_d;
      end
   end

   assign DoneFlags_o = done_q;
`else
   // Without done flags, one-shot completion is observable only through ChannelActive_o.
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: hand sequences, a pulse-count vector table and randomized traffic,
// all checked every cycle against an absolute-time reference model (BASE_DIV=4, 4 channels, 8-bit periods).

module tb_tick_scheduler;

   localparam int NCH = 4;
   localparam int DIV = 4;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       CfgValid;
   logic       CfgReady;
   logic [1:0] CfgChannel;
   logic [7:0] CfgPeriod;
   logic [1:0] CfgMode;
   logic       BaseTick;
   logic [3:0] ChannelTick;
   logic [3:0] ChannelActive;
`ifdef TICK_SCHEDULER_DONE_FLAGS_EN
   logic [3:0] DoneFlags;
`endif

   always #5 Clk = ~Clk;

   tick_scheduler #(
      .FREQUENCY_IN(8), .BASE_FREQUENCY(2), .CHANNELS(4), .PERIOD_WIDTH(8)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .CfgValid_i(CfgValid), .CfgReady_o(CfgReady), .CfgChannel_i(CfgChannel),
      .CfgPeriod_i(CfgPeriod), .CfgMode_i(CfgMode),
      .BaseTick_o(BaseTick), .ChannelTick_o(ChannelTick), .ChannelActive_o(ChannelActive)
`ifdef TICK_SCHEDULER_DONE_FLAGS_EN
      , .DoneFlags_o(DoneFlags)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cycle index since reset release, absolute time of each channel's next pulse.
   int mdl_c;
   bit mdl_ready;
   bit mdl_base;
   int mdl_mode[NCH];   // 0 idle, 1 periodic, 2 one-shot
   int mdl_p[NCH];
   int mdl_next[NCH];
   bit mdl_tick[NCH];
   bit mdl_done[NCH];

   typedef struct {
      int mode;
      int period;
      int exp_pulses;
      bit exp_active;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, mdl_c, act, exp);
      end
   endtask

   task automatic model_reset();
      mdl_c = 0;
      mdl_ready = 1'b0;
      mdl_base = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         mdl_mode[i] = 0; mdl_p[i] = 0; mdl_next[i] = 0;
         mdl_tick[i] = 1'b0; mdl_done[i] = 1'b0;
      end
   endtask

   task automatic cycle();
      bit rst_s, acc_s;
      int ch_s, p_s, m_s;
      logic [3:0] et, ea, ed;
      rst_s = Reset;
      acc_s = CfgValid && mdl_ready;
      ch_s  = int'(CfgChannel);
      p_s   = int'(CfgPeriod);
      m_s   = int'(CfgMode);
      @(posedge Clk);
      #1;
      if (!rst_s) begin
         model_reset();
      end else begin
         mdl_c++;
         if (acc_s && ch_s < NCH) begin
            mdl_done[ch_s] = 1'b0;
            if ((m_s == 1 || m_s == 2) && p_s > 0) begin
               mdl_mode[ch_s] = m_s;
               mdl_p[ch_s]    = p_s;
               // counting starts at the first BaseTick strictly after the write cycle
               mdl_next[ch_s] = DIV * ((mdl_c - 1) / DIV + p_s) + 1;
            end else begin
               mdl_mode[ch_s] = 0;
            end
         end
         mdl_ready = !acc_s;
         mdl_base  = (mdl_c % DIV == 0);
         for (int i = 0; i < NCH; i++) begin
            mdl_tick[i] = (mdl_mode[i] != 0) && (mdl_next[i] == mdl_c);
            if (mdl_tick[i]) begin
               if (mdl_mode[i] == 1) begin
                  mdl_next[i] += DIV * mdl_p[i];
               end else begin
                  mdl_mode[i] = 0;
                  mdl_done[i] = 1'b1;
               end
            end
         end
      end
      for (int i = 0; i < NCH; i++) begin
         et[i] = mdl_tick[i];
         ea[i] = (mdl_mode[i] != 0);
         ed[i] = mdl_done[i];
      end
      chk("model_basetick", 32'(BaseTick), 32'(mdl_base));
      chk("model_cfgready", 32'(CfgReady), 32'(mdl_ready));
      chk("model_chtick", 32'(ChannelTick), 32'(et));
      chk("model_chactive", 32'(ChannelActive), 32'(ea));
`ifdef TICK_SCHEDULER_DONE_FLAGS_EN
      chk("model_doneflags", 32'(DoneFlags), 32'(ed));
`else
      if (ed == 4'hF) begin
         ed = 4'h0;
      end
`endif
   endtask

   task automatic do_write(input int ch, input int mode, input int p);
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 4 && !acc; k++) begin
         CfgValid = 1'b1; CfgChannel = 2'(ch); CfgMode = 2'(mode); CfgPeriod = 8'(p);
         acc = mdl_ready;
         cycle();
      end
      CfgValid = 1'b0;
      if (!acc) begin
         n_vec++; n_err++;
         $display("FAIL write_timeout ch %0d: got no accept, expected accept within 4 cycles", ch);
      end
   endtask

   task automatic align(input int phase);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         if ((mdl_c % DIV == phase) && mdl_ready) ok = 1'b1;
         else cycle();
      end
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL align_timeout phase %0d: got cycle %0d, expected aligned ready cycle", phase, mdl_c);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w, cnt;
      logic [3:0] exp23;
      tbl[0]  = '{1, 1, 10, 1'b1};
      tbl[1]  = '{1, 2, 5, 1'b1};
      tbl[2]  = '{1, 3, 3, 1'b1};
      tbl[3]  = '{1, 5, 2, 1'b1};
      tbl[4]  = '{1, 10, 1, 1'b1};
      tbl[5]  = '{1, 11, 0, 1'b1};
      tbl[6]  = '{2, 2, 1, 1'b0};
      tbl[7]  = '{2, 11, 0, 1'b1};
      tbl[8]  = '{0, 3, 0, 1'b0};
      tbl[9]  = '{3, 3, 0, 1'b0};
      tbl[10] = '{1, 0, 0, 1'b0};
      tbl[11] = '{1, 255, 0, 1'b1};
      tbl[12] = '{2, 1, 1, 1'b0};

      model_reset();
      Reset = 1'b0; CfgValid = 1'b0; CfgChannel = 2'd0; CfgPeriod = 8'd0; CfgMode = 2'd0;

      // 1: reset for 5 cycles, then release; BaseTick every 4th cycle
      for (int k = 0; k < 5; k++) cycle();
      Reset = 1'b1;
      cycle();
      chk("ready_after_release", 32'(CfgReady), 32'd1);
      for (int k = 2; k <= 12; k++) begin
         cycle();
         chk("basetick_phase", 32'(BaseTick), (k % 4 == 0) ? 32'd1 : 32'd0);
      end

      // Vector table: program ch0 right after a BaseTick, count pulses over 40 cycles
      for (int v = 0; v < 13; v++) begin
         do_write(0, 0, 0);
         align(1);
         do_write(0, tbl[v].mode, tbl[v].period);
         cnt = 0;
         for (int k = 0; k < 39; k++) begin
            cycle();
            cnt += int'(ChannelTick[0]);
         end
         chk("table_pulse_count", 32'(cnt), 32'(tbl[v].exp_pulses));
         chk("table_active", 32'(ChannelActive[0]), 32'(tbl[v].exp_active));
      end
      do_write(0, 0, 0);

      // 3: one-shot on ch1
      align(1);
      do_write(1, 2, 2);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         cnt += int'(ChannelTick[1]);
      end
      chk("oneshot_pulses", 32'(cnt), 32'd1);
      chk("oneshot_inactive", 32'(ChannelActive[1]), 32'd0);
`ifdef TICK_SCHEDULER_DONE_FLAGS_EN
      chk("oneshot_done", 32'(DoneFlags[1]), 32'd1);
      do_write(1, 0, 0);
      chk("done_cleared", 32'(DoneFlags[1]), 32'd0);
`endif

      // 4: CfgValid held for ch2 then ch3, P=1 periodic
      align(1);
      w = mdl_c;
      CfgValid = 1'b1; CfgChannel = 2'd2; CfgMode = 2'd1; CfgPeriod = 8'd1;
      cycle();
      chk("b2b_ready_low", 32'(CfgReady), 32'd0);
      CfgChannel = 2'd3;
      cycle();
      chk("b2b_ready_back", 32'(CfgReady), 32'd1);
      cycle();
      CfgValid = 1'b0;
      chk("b2b_second_accept", 32'(CfgReady), 32'd0);
      while (mdl_c < w + 3) cycle();
      for (int k = 0; k < 16; k++) begin
         cycle();
         exp23 = ((mdl_c - w) % 4 == 0) ? 4'b1100 : 4'b0000;
         chk("b2b_same_cycle", 32'(ChannelTick & 4'b1100), 32'(exp23));
      end
      do_write(2, 0, 0);
      do_write(3, 0, 0);

      // 5: stop written in the BaseTick cycle that would expire ch0
      align(1);
      w = mdl_c;
      do_write(0, 1, 2);
      while (mdl_c < w + 7) cycle();
      chk("stop_in_base_cycle", 32'(BaseTick), 32'd1);
      chk("stop_still_active", 32'(ChannelActive[0]), 32'd1);
      do_write(0, 0, 0);
      chk("stop_no_tick", 32'(ChannelTick[0]), 32'd0);
      chk("stop_inactive", 32'(ChannelActive[0]), 32'd0);
      do_write(0, 1, 0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         cnt += int'(ChannelActive[0]);
      end
      chk("p0_stays_idle", 32'(cnt), 32'd0);

      // 6: reset while ch0 is periodic with counter at 0
      do_write(0, 1, 1);
      do_write(1, 1, 3);
      align(0);
      Reset = 1'b0;
      cycle();
      chk("rst_no_tick", 32'(ChannelTick), 32'd0);
      chk("rst_inactive", 32'(ChannelActive), 32'd0);
      cycle();
      cycle();
      Reset = 1'b1;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         cycle();
         cnt += $countones(ChannelTick);
      end
      chk("post_rst_silent", 32'(cnt), 32'd0);
      chk("post_rst_idle", 32'(ChannelActive), 32'd0);

      // Randomized traffic against the model, with occasional resets
      for (int k = 0; k < 1000; k++) begin
         int r;
         Reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         CfgValid = ($urandom_range(0, 3) == 0);
         CfgChannel = 2'($urandom_range(0, 3));
         r = int'($urandom_range(0, 9));
         CfgMode = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
         CfgPeriod = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
         cycle();
      end
      Reset = 1'b1;
      CfgValid = 1'b0;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
